sd_cmd_phy: RTL and testbench
=============================

Name: sd_cmd_phy

Overview:
- Parametrised successor to the single-purpose CMD line driver; owns the SD CMD line end to end.
- Serialises a 48-bit command frame with the CRC7 generated on the fly.
- Receives the optional response: none, short 48-bit (R1/R3/R6/R7) or long 136-bit (R2).
- Checks the response with CRC7, end bit and timeout; sits between the SD controller FSM and the CMD pad tristate.

Parameters:
NCR_MAX, 64, max clk cycles after command end bit to wait for response start bit (counter width = clog2(NCR_MAX+1))
NCC, 8, idle clk cycles driven high after command (no response) or after response end bit, before done
RESP_W, 128, width of resp output; must be >= 127

Ports:
clk  in  1  SD clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; ignored unless busy=0
cmd_index  in  6  command index, sampled on accepted start
cmd_arg  in  32  command argument, sampled on accepted start
resp_type  in  2  00 none, 01 short, 10 long, 11 treated as short; sampled on start
crc_chk  in  1  1 = check response CRC (0 for R3); sampled on start
cmd_i  in  1  CMD pad input (pre-synchronised)
cmd_o  out  1  CMD pad output value
cmd_oe  out  1  CMD pad output enable
busy  out  1  high from cycle after accepted start until done pulse (inclusive)
done  out  1  one-cycle completion pulse
resp  out  RESP_W  received response bits (see below); held until next accepted start
timeout  out  1  valid with done; no start bit within NCR_MAX
crc_err  out  1  valid with done; CRC7 mismatch
end_err  out  1  valid with done; response end bit = 0

Behaviour:
- Reset values: cmd_o=1, cmd_oe=0, busy=0, done=0, resp=0, timeout=0, crc_err=0, end_err=0; FSM=IDLE. Reset mid-operation aborts immediately and releases the line.
- FSM states: IDLE, SEND, WAIT, RECV, GAP, DONE.
- IDLE: start=1 latches the inputs and clears resp and all flags; go to SEND.
- SEND: 48 cycles with cmd_oe=1, MSB first.
  - Frame = 0, 1, cmd_index[5:0], cmd_arg[31:0], CRC7[6:0], 1.
  - CRC7 polynomial x^7+x^3+1, init 0, computed over the first 40 bits.
  - First bit (0) is on cmd_o in the cycle after start is accepted.
- After the end bit: cmd_oe=0, cmd_o=1.
  - resp_type=00: go to GAP.
  - Otherwise: go to WAIT.
- WAIT: counter runs from 1.
  - cmd_i=0 seen: go to RECV; that bit is the start bit and is not stored.
  - Counter reaches NCR_MAX with cmd_i=1: timeout=1, go to DONE, no GAP.
- RECV: remaining bits are shifted in MSB first.
  - Short: 47 bits. resp[45:0]={transmission bit, index[5:0], arg[31:0], crc[6:0]}; upper bits 0. CRC7 covers start bit + 39 following bits and is compared to the received crc.
  - Long: 135 bits. resp[126:0] = the 127 bits preceding the end bit (CID/CSD[127:1]); resp[RESP_W-1:127]=0. CRC7 covers CID/CSD[127:8], i.e. the 120 bits after the 8 header bits, and is compared to resp[6:0].
  - Last bit received is the end bit; end_err = ~bit.
  - crc_err is set only if crc_chk=1.
  - Then go to GAP.
- GAP: NCC cycles, cmd_oe=0; then DONE.
- DONE: done=1 for one cycle; busy drops the next cycle; return to IDLE. A start in the DONE cycle is ignored.
- Flags are sticky until the next accepted start.
- start while busy=1 is ignored with no side effect.
- cmd_i is ignored outside WAIT/RECV.
- Latency: no-response command = 48+NCC+1 cycles from accept to done.

Test Plan:
- Reset mid-SEND (rst at bit 20 of CMD0) -> next cycle cmd_oe=0, cmd_o=1, busy=0, done=0; next start works normally.
- CMD0 arg 0x00000000, resp_type=00 -> cmd_o stream = 0x400000000095; done exactly 57 cycles after start; all flags 0.
- CMD8 arg 0x000001AA, resp_type=01; bench returns a short response 4 cycles after the end bit with correct CRC7 (from the bench reference model).
  - Bench drives {0, 0, 6'd8, 32'h000001AA, crc, 1} -> cmd_o stream 0x48000001AA87; resp[45:0] matches; crc_err=0, end_err=0, timeout=0.
- Same response with arg bit 0 flipped -> crc_err=1. Repeat with crc_chk=0 -> crc_err=0.
- CMD55 arg 0, resp_type=01, cmd_i held 1 -> cmd_o stream 0x770000000065; timeout=1 after NCR_MAX=64 cycles; done with no GAP; resp=0.
- CMD2, resp_type=10; bench drives a 136-bit R2 with CID = 0x0123456789ABCDEF_FEDCBA987654321 (120 bits), correct CRC7, and end bit 0 -> resp[126:7] = CID; crc_err=0, end_err=1. A second start pulsed mid-RECV is ignored.

Source files
------------

// File: rtl/sd_cmd_phy.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sd_cmd_phy
//   SD CMD line PHY. Serialises a 48-bit command frame and generates its CRC7
//   on the fly. Optionally receives a short (48-bit) or long (136-bit)
//   response and checks its CRC7, end bit and start-bit timeout. The block
//   sits between the SD controller FSM and the CMD pad tristate.
//
// Ports
//   clk        SD clock; all logic on the rising edge
//   rst        asynchronous, active-high reset; aborts and releases the line
//   start      one-cycle request, accepted only while idle (busy = 0)
//   cmd_index  command index, sampled on an accepted start
//   cmd_arg    command argument, sampled on an accepted start
//   resp_type  00 none, 01 short, 10 long, 11 short; sampled on start
//   crc_chk    1 = check the response CRC7; sampled on start
//   cmd_i      CMD pad input (already synchronised)
//   cmd_o      CMD pad output value
//   cmd_oe     CMD pad output enable
//   busy       high from the cycle after accept through the done cycle
//   done       one-cycle completion pulse
//   resp       received response bits, held until the next accepted start
//   timeout    no response start bit within NCR_MAX cycles (valid with done)
//   crc_err    response CRC7 mismatch (valid with done)
//   end_err    response end bit was 0 (valid with done)
//
// NCC must be at least 1.
// -----------------------------------------------------------------------------
module sd_cmd_phy #(
  parameter int NCR_MAX = 64,
  parameter int NCC     = 8,
  parameter int RESP_W  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        cmd_index,
  input  logic [31:0]       cmd_arg,
  input  logic [1:0]        resp_type,
  input  logic              crc_chk,
  input  logic              cmd_i,
  output logic              cmd_o,
  output logic              cmd_oe,
  output logic              busy,
  output logic              done,
  output logic [RESP_W-1:0] resp,
  output logic              timeout,
  output logic              crc_err,
  output logic              end_err
);

  localparam int NCR_W = $clog2(NCR_MAX + 1);
  localparam int GAP_W = (NCC > 1) ? $clog2(NCC) : 1;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, GAP, DONE} state_e;

  // One CRC7 step, polynomial x^7 + x^3 + 1, MSB-first serial input.
  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  state_e              state_q;
  logic [38:0]         tx_q;        // frame bits 1..39 still to be sent
  logic [7:0]          bit_q;       // bit position within SEND / RECV
  logic [NCR_W-1:0]    ncr_q;
  logic [GAP_W-1:0]    gap_q;
  logic [6:0]          crc_q;
  logic                has_resp_q;
  logic                long_q;
  logic                crc_chk_q;
  logic                cmd_o_q;
  logic                cmd_oe_q;
  logic                busy_q;
  logic                done_q;
  logic [RESP_W-1:0]   resp_q;
  logic                timeout_q;
  logic                crc_err_q;
  logic                end_err_q;

  // CRC input: the bit currently on the line while sending, the pad while
  // receiving.
  logic       crc_bit;
  logic [6:0] crc_d;

  // NOTE: both signals are assigned on every path, so no latch is inferred.
  always_comb begin
    crc_bit = (state_q == RECV) ? cmd_i : cmd_o_q;
    crc_d   = crc7_next(crc_q, crc_bit);
  end

  // Receive bit classification. Long responses skip the 7 header bits after
  // the start bit; their CRC covers CID/CSD[127:8] (positions 7..126).
  logic       rx_crc_en;
  logic       rx_store;
  logic       rx_last;

  always_comb begin
    rx_crc_en = long_q ? (bit_q >= 8'd7 && bit_q <= 8'd126) : (bit_q <= 8'd38);
    rx_store  = long_q ? (bit_q >= 8'd7) : 1'b1;
    rx_last   = long_q ? (bit_q == 8'd134) : (bit_q == 8'd46);
  end

  // NOTE: every register below is updated with non-blocking assignments, so
  // all branches see the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      bit_q      <= '0;
      ncr_q      <= '0;
      gap_q      <= '0;
      crc_q      <= '0;
      has_resp_q <= 1'b0;
      long_q     <= 1'b0;
      crc_chk_q  <= 1'b0;
      cmd_o_q    <= 1'b1;
      cmd_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      // NOTE: resp is a flop array, not a RAM, so it is cleared by reset too.
      resp_q     <= '0;
      timeout_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            tx_q       <= {1'b1, cmd_index, cmd_arg};
            has_resp_q <= (resp_type != 2'b00);
            long_q     <= (resp_type == 2'b10);
            crc_chk_q  <= crc_chk;
            resp_q     <= '0;
            timeout_q  <= 1'b0;
            crc_err_q  <= 1'b0;
            end_err_q  <= 1'b0;
            crc_q      <= '0;
            bit_q      <= '0;
            cmd_o_q    <= 1'b0;  // frame start bit
            cmd_oe_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
          end
        end

        SEND: begin
          // Bits 0..39 feed the CRC; the result then shifts out as bits 40..46.
          if (bit_q <= 8'd39) crc_q <= crc_d;
          else                crc_q <= {crc_q[5:0], 1'b0};

          if (bit_q < 8'd39)       cmd_o_q <= tx_q[38];
          else if (bit_q == 8'd39) cmd_o_q <= crc_d[6];
          else if (bit_q < 8'd46)  cmd_o_q <= crc_q[5];
          else                     cmd_o_q <= 1'b1;  // end bit, then idle high

          tx_q  <= {tx_q[37:0], 1'b0};
          bit_q <= bit_q + 8'd1;

          if (bit_q == 8'd47) begin
            cmd_oe_q <= 1'b0;
            if (has_resp_q) begin
              ncr_q   <= NCR_W'(1);
              state_q <= WAIT;
            end else begin
              gap_q   <= '0;
              state_q <= GAP;
            end
          end
        end

        WAIT: begin
          if (!cmd_i) begin
            // Start bit: not stored; as a 0 it leaves the zero CRC unchanged.
            bit_q   <= '0;
            crc_q   <= '0;
            state_q <= RECV;
          end else if (ncr_q == NCR_W'(NCR_MAX)) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            ncr_q <= ncr_q + NCR_W'(1);
          end
        end

        RECV: begin
          if (rx_crc_en) crc_q <= crc_d;
          if (rx_last) begin
            end_err_q <= ~cmd_i;
            crc_err_q <= crc_chk_q && (crc_q != resp_q[6:0]);
            gap_q     <= '0;
            state_q   <= GAP;
          end else begin
            if (rx_store) resp_q <= {resp_q[RESP_W-2:0], cmd_i};
            bit_q <= bit_q + 8'd1;
          end
        end

        GAP: begin
          if (gap_q == GAP_W'(NCC - 1)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_o   = cmd_o_q;
  assign cmd_oe  = cmd_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign resp    = resp_q;
  assign timeout = timeout_q;
  assign crc_err = crc_err_q;
  assign end_err = end_err_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
`timescale 1ns/1ps
// Directed bench for sd_cmd_phy. Inputs are driven and outputs sampled on the
// falling clock edge; the DUT acts on the rising edge.
module tb_sd_cmd_phy;

  localparam int RESP_W = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [5:0]        cmd_index = '0;
  logic [31:0]       cmd_arg = '0;
  logic [1:0]        resp_type = '0;
  logic              crc_chk = 1'b1;
  logic              cmd_i = 1'b1;
  logic              cmd_o;
  logic              cmd_oe;
  logic              busy;
  logic              done;
  logic [RESP_W-1:0] resp;
  logic              timeout;
  logic              crc_err;
  logic              end_err;

  int tests_run = 0;
  int tests_failed = 0;

  sd_cmd_phy #(.NCR_MAX(64), .NCC(8), .RESP_W(RESP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .resp_type (resp_type),
    .crc_chk   (crc_chk),
    .cmd_i     (cmd_i),
    .cmd_o     (cmd_o),
    .cmd_oe    (cmd_oe),
    .busy      (busy),
    .done      (done),
    .resp      (resp),
    .timeout   (timeout),
    .crc_err   (crc_err),
    .end_err   (end_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [RESP_W-1:0] observed,
                       input logic [RESP_W-1:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference CRC7 over the low n bits of v, MSB first.
  function automatic logic [6:0] crc7_bits(input logic [135:0] v, input int n);
    logic [6:0] c;
    c = '0;
    for (int i = n - 1; i >= 0; i--)
      c = {c[5:0], 1'b0} ^ (((c[6] ^ v[i]) == 1'b1) ? 7'h09 : 7'h00);
    return c;
  endfunction

  // Called on a falling edge; returns on the falling edge showing the 48th bit.
  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [1:0] rt, input logic chk,
                          output logic [47:0] stream, output logic oe_ok);
    start     = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    resp_type = rt;
    crc_chk   = chk;
    stream    = '0;
    oe_ok     = 1'b1;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      start  = 1'b0;
      stream = {stream[46:0], cmd_o};
      oe_ok  = oe_ok & cmd_oe;
    end
  endtask

  // Waits `delay` cycles, then drives nbits MSB first; optionally pulses a
  // conflicting start at bit index pulse_idx. busy must stay high throughout.
  task automatic drive_resp(input logic [135:0] bits, input int nbits,
                            input int delay, input int pulse_idx,
                            output logic busy_ok);
    busy_ok = 1'b1;
    for (int d = 0; d < delay; d++) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      cmd_i = bits[nbits-1-i];
      if (i == pulse_idx) begin
        start     = 1'b1;
        cmd_index = 6'h3F;
        resp_type = 2'b00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      busy_ok = busy_ok & busy;
    end
    start = 1'b0;
    cmd_i = 1'b1;
  endtask

  task automatic wait_done(input int max_cycles, output int n, output logic seen);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < max_cycles) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  logic [47:0]  stream;
  logic         oe_ok;
  logic         busy_ok;
  logic         seen;
  int           n;
  logic [6:0]   crc;
  logic [47:0]  r7;
  logic [47:0]  r7f;
  logic [119:0] cid;
  logic [135:0] r2;

  initial begin
    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    check("rst_cmd_o", cmd_o, 1);
    check("rst_cmd_oe", cmd_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_resp", resp, 0);
    check("rst_flags", {timeout, crc_err, end_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- reset in the middle of CMD0 ----------------
    start = 1'b1; cmd_index = 6'd0; cmd_arg = 32'h0; resp_type = 2'b00; crc_chk = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_send_oe", cmd_oe, 1);
    check("mid_send_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_cmd_oe", cmd_oe, 0);
    check("abort_cmd_o", cmd_o, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- CMD0, no response ----------------
    send_cmd(6'd0, 32'h0000_0000, 2'b00, 1'b1, stream, oe_ok);
    check("cmd0_stream", stream, 48'h400000000095);
    check("cmd0_oe", oe_ok, 1);
    wait_done(30, n, seen);
    check("cmd0_done_seen", seen, 1);
    check("cmd0_latency", 48 + n, 57);
    check("cmd0_busy_at_done", busy, 1);
    check("cmd0_flags", {timeout, crc_err, end_err}, 0);
    @(negedge clk);
    check("cmd0_busy_after", busy, 0);
    check("cmd0_done_pulse", done, 0);

    // ---------------- CMD8, good short response ----------------
    crc = crc7_bits({96'b0, 2'b00, 6'd8, 32'h0000_01AA}, 40);
    r7  = {2'b00, 6'd8, 32'h0000_01AA, crc, 1'b1};
    send_cmd(6'd8, 32'h0000_01AA, 2'b01, 1'b1, stream, oe_ok);
    check("cmd8_stream", stream, 48'h48000001AA87);
    drive_resp({88'b0, r7}, 48, 4, -1, busy_ok);
    wait_done(40, n, seen);
    check("cmd8_done_seen", seen, 1);
    check("cmd8_busy", busy_ok, 1);
    check("cmd8_resp", resp, {82'b0, r7[46:1]});
    check("cmd8_flags", {timeout, crc_err, end_err}, 0);
    @(negedge clk);

    // ---------------- CMD8, corrupted arg bit 0, CRC checked ----------------
    r7f = r7 ^ 48'h0000_0000_0100;
    send_cmd(6'd8, 32'h0000_01AA, 2'b01, 1'b1, stream, oe_ok);
    drive_resp({88'b0, r7f}, 48, 4, -1, busy_ok);
    wait_done(40, n, seen);
    check("bad_crc_done_seen", seen, 1);
    check("bad_crc_resp", resp, {82'b0, r7f[46:1]});
    check("bad_crc_flags", {timeout, crc_err, end_err}, 3'b010);
    @(negedge clk);
    check("bad_crc_sticky", crc_err, 1);

    // ---------------- same corruption, CRC check off ----------------
    send_cmd(6'd8, 32'h0000_01AA, 2'b01, 1'b0, stream, oe_ok);
    drive_resp({88'b0, r7f}, 48, 4, -1, busy_ok);
    wait_done(40, n, seen);
    check("nochk_done_seen", seen, 1);
    check("nochk_flags", {timeout, crc_err, end_err}, 0);
    @(negedge clk);

    // ---------------- CMD55, no response -> timeout ----------------
    send_cmd(6'd55, 32'h0000_0000, 2'b01, 1'b1, stream, oe_ok);
    check("cmd55_stream", stream, 48'h770000000065);
    wait_done(100, n, seen);
    check("cmd55_done_seen", seen, 1);
    check("cmd55_latency", 48 + n, 48 + 1 + 64);
    check("cmd55_flags", {timeout, crc_err, end_err}, 3'b100);
    check("cmd55_resp_cleared", resp, 0);
    check("cmd55_line_released", {cmd_oe, cmd_o}, 2'b01);
    // start during the done cycle must be ignored
    start = 1'b1; cmd_index = 6'd0; resp_type = 2'b00;
    @(negedge clk);
    start = 1'b0;
    check("done_cycle_start_busy", busy, 0);
    check("done_cycle_start_oe", cmd_oe, 0);
    check("timeout_sticky", timeout, 1);
    @(negedge clk);

    // ---------------- CMD2, long response, bad end bit ----------------
    cid = 120'h123456789ABCDEF_FEDCBA987654321;
    crc = crc7_bits({16'b0, cid}, 120);
    r2  = {1'b0, 1'b0, 6'b111111, cid, crc, 1'b0};
    send_cmd(6'd2, 32'h0000_0000, 2'b10, 1'b1, stream, oe_ok);
    drive_resp(r2, 136, 4, 60, busy_ok);
    wait_done(40, n, seen);
    check("cmd2_done_seen", seen, 1);
    check("cmd2_busy", busy_ok, 1);
    check("cmd2_resp", resp, {1'b0, cid, crc});
    check("cmd2_flags", {timeout, crc_err, end_err}, 3'b001);
    @(negedge clk);
    check("cmd2_idle_busy", busy, 0);
    check("cmd2_idle_oe", cmd_oe, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
